imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Parametrised, pipelined immediate generator for the CPU decode stage. It extends the combinational sign extender with configurable output width, MOVN/MOVK wide-move formats and a registered valid/ready output stage. It sits between instruction decode and the register-read/ALU operand mux. A 2-entry skid buffer keeps full throughput under downstream stall.

## Interface
- WIDTH, 64, output immediate width; legal values 32 or 64.
- CLK  input  1  rising-edge clock.
- resetn  input  1  reset; synchronous and active-low.
- in_valid  input  1  op/in26/hw are valid this cycle.
- in_ready  output  1  block can accept this cycle; transfer when in_valid & in_ready.
- in26  input  26  instruction bits [25:0].
- op  input  3  format: 000 I, 001 D, 010 B, 011 CBZ, 100 MOVZ, 101 MOVK, 110 MOVN, 111 reserved.
- hw  input  2  wide-move shift, in units of 16 bits (0..3).
- out_valid  output  1  imm/err are valid.
- out_ready  input  1  consumer accepts; transfer when out_valid & out_ready.
- imm  output  WIDTH  generated immediate.
- err  output  1  illegal request; imm is 0 when set.

## Operation
- Field extraction:
  - I: zero-extend in26[21:10] (12 b).
  - D: sign-extend in26[20:12] (9 b).
  - B: sign-extend in26[25:0].
  - CBZ: sign-extend in26[23:5] (19 b).
  - Wide moves: imm16 = in26[20:5].
- Width rule: extend to 64 bits, then truncate to WIDTH.
- MOVZ: imm16 << 16*hw.
- MOVN: ~(imm16 << 16*hw), truncated to WIDTH.
- MOVK: accumulator with bits [16*hw+15 : 16*hw] replaced by imm16.
- Accumulator (WIDTH bits):
  - Loaded with the result of every accepted MOVZ/MOVN/MOVK that has err=0.
  - Reset value 0.
  - Not touched by I/D/B/CBZ or by erroring requests.
- err=1, imm=0, accumulator unchanged when:
  - op=111, or
  - WIDTH=32 and op is a wide move with hw>=2.
- Results are computed at input acceptance, so a MOVK sees the immediately preceding accepted wide move even when it is still held in the buffer.
- Output order equals acceptance order. No reordering, no drops.

## Timing
- Latency: accepted in cycle N, presented on imm/out_valid in cycle N+1.
- Throughput: 1 per cycle while out_ready=1.
- Skid buffer:
  - Main register plus one skid entry.
  - in_ready = ~skid_full, registered.
  - With out_ready held low, exactly 2 requests are accepted; in_ready drops the cycle after the second acceptance.
  - in_ready rises the cycle after the first output transfer frees the skid entry.
- Simultaneous accept and transfer while full-main/empty-skid: the new entry moves into main with no bubble.
- imm/err hold stable while out_valid=1 and out_ready=0.
- Reset (resetn=0 at a rising edge):
  - out_valid=0, imm=0, err=0, in_ready=0 during reset.
  - Both buffer entries are cleared and accumulator=0, including mid-stream with entries pending; pending entries are discarded.
  - in_ready=1 in the first cycle after resetn is high.
- Inputs are ignored whenever in_ready=0.

## Configuration
- IMMGEN_MOVK_EN defined:
  - MOVK and the accumulator are built as described.
- IMMGEN_MOVK_EN undefined:
  - No accumulator register is built.
  - op=101 is treated as reserved: err=1, imm=0.
  - All other formats behave identically.

## Structure
- Package imm_gen_pkg holds:
  - Op-encoding localparams (OP_I … OP_RSVD).
  - Field positions and widths (12/9/26/19/16).
  - HW_SHIFT = 16.
- Sub-module imm_skid_buf:
  - Generic 2-entry valid/ready skid buffer, parameter DW = WIDTH+1 (imm plus err).
  - Instantiated once.
- Top level holds the combinational format generator, error check and accumulator.

## Test plan
- **I/D/CBZ formats:**
  - I with in26[21:10]=12'hFFF -> imm=64'h0000_0000_0000_0FFF one cycle after acceptance.
  - D with in26[20:12]=9'h1F0 -> 64'hFFFF_FFFF_FFFF_FFF0.
  - CBZ with in26[23:5]=19'h40000 -> 64'hFFFF_FFFF_FFFC_0000.
- **MOVK chain:** back-to-back, no stall.
  - MOVZ hw=3 imm16=16'h1234 -> 64'h1234_0000_0000_0000.
  - MOVK hw=0 imm16=16'hABCD -> 64'h1234_0000_0000_ABCD.
  - MOVN hw=0 imm16=0 -> 64'hFFFF_FFFF_FFFF_FFFF.
- **Backpressure:** out_ready=0 for 4 cycles while offering 3 I-type requests with values 1, 2, 3 every cycle.
  - Only 1 and 2 are accepted; in_ready=0 from the cycle after the second acceptance.
  - After out_ready=1: outputs 1, 2, 3 in order with no duplicates.
- **WIDTH=32:**
  - MOVZ hw=2 -> err=1, imm=0.
  - B with in26=26'h2000000 -> 32'hFE00_0000.
  - MOVN hw=1 imm16=16'h0001 -> 32'hFFFE_FFFF.
- **Reserved and macro-off:**
  - op=111 -> err=1, imm=0, accumulator unchanged; verified by a following MOVK hw=0 0x0001 returning the prior accumulator with only the low 16 bits replaced.
  - With IMMGEN_MOVK_EN undefined, op=101 -> err=1.
- **Reset mid-stream:** both buffer entries full, accumulator=0x1234_0000_0000_0000, resetn=0 for one cycle.
  - Next cycle: out_valid=0, in_ready=1.
  - Following MOVK hw=0 16'h0001 -> 64'h0000_0000_0000_0001.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared definitions for the pipelined immediate generator.
//   - op encodings OP_I .. OP_RSVD
//   - field positions / widths inside the 26-bit instruction slice
//   - HW_SHIFT: wide-move shift granule in bits
//   - is_wide(): true for MOVZ / MOVK / MOVN
package imm_gen_pkg;

    localparam logic [2:0] OP_I    = 3'b000;
    localparam logic [2:0] OP_D    = 3'b001;
    localparam logic [2:0] OP_B    = 3'b010;
    localparam logic [2:0] OP_CBZ  = 3'b011;
    localparam logic [2:0] OP_MOVZ = 3'b100;
    localparam logic [2:0] OP_MOVK = 3'b101;
    localparam logic [2:0] OP_MOVN = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    localparam int I_LSB   = 10;
    localparam int I_W     = 12;
    localparam int D_LSB   = 12;
    localparam int D_W     = 9;
    localparam int B_W     = 26;
    localparam int CBZ_LSB = 5;
    localparam int CBZ_W   = 19;
    localparam int MOV_LSB = 5;
    localparam int MOV_W   = 16;

    localparam int HW_SHIFT = 16;

    function automatic logic is_wide(input logic [2:0] op);
        return (op == OP_MOVZ) || (op == OP_MOVK) || (op == OP_MOVN);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: request/response bundle of the immediate generator.
//   request  : in_valid, in_ready, in26, op, hw
//   response : out_valid, out_ready, imm, err
//   master   : drives requests, consumes responses (decode side / bench)
//   slave    : the generator itself
interface imm_gen_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [25:0]      in26;
    logic [2:0]       op;
    logic [1:0]       hw;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] imm;
    logic             err;

    modport master (
        output in_valid, in26, op, hw, out_ready,
        input  in_ready, out_valid, imm, err
    );

    modport slave (
        input  in_valid, in26, op, hw, out_ready,
        output in_ready, out_valid, imm, err
    );
endinterface

// File: rtl/imm_skid_buf.sv
// imm_skid_buf: generic 2-entry valid/ready buffer (main register + skid).
//   CLK, resetn          : clock, synchronous active-low reset
//   in_valid/in_ready    : upstream handshake, in_data payload
//   out_valid/out_ready  : downstream handshake, out_data payload
// in_ready depends only on registered skid occupancy, so no combinational
// path runs from out_ready back to in_ready.
module imm_skid_buf #(
    parameter int DW = 65
) (
    input  logic          CLK,
    input  logic          resetn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);
    logic          main_valid;
    logic          skid_valid;
    logic [DW-1:0] main_data;
    logic [DW-1:0] skid_data;
    logic          in_fire;
    logic          main_free;

    // Outputs are forced idle while resetn is low so nothing stale leaks out.
    assign in_ready  = resetn & ~skid_valid;
    assign out_valid = resetn & main_valid;
    assign out_data  = resetn ? main_data : '0;

    assign in_fire   = in_valid & in_ready;
    assign main_free = ~main_valid | out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            // NOTE: payload registers are cleared as well, because pending
            // entries must be discarded and imm must read 0 after reset.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (main_free) begin
            if (skid_valid) begin
                // in_ready is low while skid is occupied, so no new entry here.
                main_data  <= skid_data;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= in_fire;
                if (in_fire) main_data <= in_data;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator for the decode stage.
//   CLK     : rising-edge clock
//   resetn  : synchronous active-low reset
//   bus     : imm_gen_pipe_if.slave (in_valid/in_ready/in26/op/hw,
//             out_valid/out_ready/imm/err)
//   WIDTH   : output immediate width, 32 or 64
// Build option IMMGEN_MOVK_EN: when defined, MOVK and the wide-move
// accumulator are built; otherwise op=101 is reported as reserved.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input logic           CLK,
    input logic           resetn,
    imm_gen_pipe_if.slave bus
);
    logic [MOV_W-1:0] imm16;
    logic [5:0]       shamt;
    logic [63:0]      wide64;
    logic [63:0]      res64;
    logic [WIDTH-1:0] res;
    logic             err;
    logic [WIDTH:0]   out_data;

    assign imm16  = bus.in26[MOV_LSB +: MOV_W];
    // hw counts HW_SHIFT (16-bit) granules: 16*hw is hw followed by four zeros.
    assign shamt  = {bus.hw, 4'b0000};
    assign wide64 = {48'b0, imm16} << shamt;

`ifdef IMMGEN_MOVK_EN
    logic [WIDTH-1:0] acc_q;
    logic [63:0]      acc64;
    logic [63:0]      mask64;
    logic             in_fire;

    assign acc64   = 64'(acc_q);
    assign mask64  = {48'b0, 16'hFFFF} << shamt;
    assign in_fire = bus.in_valid & bus.in_ready;
`endif

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value held and infer a latch.
    always_comb begin
        res64 = '0;
        err   = 1'b0;
        case (bus.op)
            OP_I:    res64 = 64'(bus.in26[I_LSB +: I_W]);
            OP_D:    res64 = 64'($signed(bus.in26[D_LSB +: D_W]));
            OP_B:    res64 = 64'($signed(bus.in26[B_W-1:0]));
            OP_CBZ:  res64 = 64'($signed(bus.in26[CBZ_LSB +: CBZ_W]));
            OP_MOVZ: res64 = wide64;
            OP_MOVN: res64 = ~wide64;
`ifdef IMMGEN_MOVK_EN
            OP_MOVK: res64 = (acc64 & ~mask64) | wide64;
`endif
            default: err   = 1'b1;
        endcase
        // A 32-bit result has no halfwords 2 and 3 to move into.
        if (WIDTH == 32 && is_wide(bus.op) && bus.hw[1]) err = 1'b1;
        if (err) res64 = '0;
    end

    assign res = res64[WIDTH-1:0];

`ifdef IMMGEN_MOVK_EN
    // Updated at acceptance, so a following MOVK sees this result even while
    // it is still waiting in the output buffer.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            acc_q <= '0;
        end else if (in_fire && is_wide(bus.op) && !err) begin
            acc_q <= res;
        end
    end
`endif

    imm_skid_buf #(
        .DW(WIDTH + 1)
    ) u_skid (
        .CLK      (CLK),
        .resetn   (resetn),
        .in_valid (bus.in_valid),
        .in_ready (bus.in_ready),
        .in_data  ({err, res}),
        .out_valid(bus.out_valid),
        .out_ready(bus.out_ready),
        .out_data (out_data)
    );

    assign bus.err = out_data[WIDTH];
    assign bus.imm = out_data[WIDTH-1:0];
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed self-checking bench for imm_gen_pipe.
// Two instances (WIDTH=64 and WIDTH=32) share clock and reset. Expected
// results are queued at acceptance and compared when each output transfers.
// Expectations for op=101 follow the IMMGEN_MOVK_EN build option.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    typedef struct {
        logic        err;
        logic [63:0] imm;
    } exp_t;

    logic CLK;
    logic resetn;

    int checks = 0;
    int errors = 0;

    exp_t q64[$];
    exp_t q32[$];
    exp_t m64_e;
    exp_t m32_e;

    imm_gen_pipe_if #(.WIDTH(64)) b64 ();
    imm_gen_pipe_if #(.WIDTH(32)) b32 ();

    imm_gen_pipe #(.WIDTH(64)) dut64 (.CLK(CLK), .resetn(resetn), .bus(b64));
    imm_gen_pipe #(.WIDTH(32)) dut32 (.CLK(CLK), .resetn(resetn), .bus(b32));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output monitors: compare each transfer against the scoreboard head.
    always @(negedge CLK) begin
        if (b64.out_valid === 1'b1 && b64.out_ready === 1'b1) begin
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL out64_unexpected observed=%h expected=none", b64.imm);
            end else begin
                m64_e = q64.pop_front();
                check("out64", {b64.err, b64.imm}, {m64_e.err, m64_e.imm});
            end
        end
    end

    always @(negedge CLK) begin
        if (b32.out_valid === 1'b1 && b32.out_ready === 1'b1) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL out32_unexpected observed=%h expected=none", b32.imm);
            end else begin
                m32_e = q32.pop_front();
                check("out32", {b32.err, 32'h0, b32.imm}, {m32_e.err, m32_e.imm});
            end
        end
    end

    // Drive one request and hold it until accepted; returns at posedge+1.
    task automatic send64(input logic [2:0] op, input logic [1:0] hw, input logic [25:0] in26,
                          input logic e, input logic [63:0] x);
        b64.op = op; b64.hw = hw; b64.in26 = in26; b64.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (b64.in_ready === 1'b1) begin
                q64.push_back('{e, x});
                @(posedge CLK); #1;
                b64.in_valid = 1'b0;
                return;
            end
            @(posedge CLK); #1;
        end
        checks++;
        errors++;
        $error("FAIL send64_timeout observed=in_ready_low expected=accept");
        b64.in_valid = 1'b0;
    endtask

    task automatic send32(input logic [2:0] op, input logic [1:0] hw, input logic [25:0] in26,
                          input logic e, input logic [63:0] x);
        b32.op = op; b32.hw = hw; b32.in26 = in26; b32.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (b32.in_ready === 1'b1) begin
                q32.push_back('{e, x});
                @(posedge CLK); #1;
                b32.in_valid = 1'b0;
                return;
            end
            @(posedge CLK); #1;
        end
        checks++;
        errors++;
        $error("FAIL send32_timeout observed=in_ready_low expected=accept");
        b32.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50; i++) begin
            if (q64.size() == 0 && q32.size() == 0) break;
            @(posedge CLK); #1;
        end
        check("drain64", 65'(q64.size()), 65'd0);
        check("drain32", 65'(q32.size()), 65'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        b64.in_valid = 1'b0; b64.op = OP_I; b64.hw = 2'd0; b64.in26 = '0; b64.out_ready = 1'b1;
        b32.in_valid = 1'b0; b32.op = OP_I; b32.hw = 2'd0; b32.in26 = '0; b32.out_ready = 1'b1;

        // Reset state.
        @(negedge CLK);
        check("rst_in_ready64", 65'(b64.in_ready), 65'd0);
        check("rst_out_valid64", 65'(b64.out_valid), 65'd0);
        @(posedge CLK); #1;
        resetn = 1'b1;
        @(negedge CLK);
        check("post_rst_in_ready64", 65'(b64.in_ready), 65'd1);
        check("post_rst_in_ready32", 65'(b32.in_ready), 65'd1);
        check("post_rst_imm64", {b64.err, b64.imm}, 65'd0);
        @(posedge CLK); #1;

        // I / D / CBZ formats, with a one-cycle latency check on the first.
        send64(OP_I, 2'd0, 26'(12'hFFF) << 10, 1'b0, 64'h0000_0000_0000_0FFF);
        @(negedge CLK);
        check("lat_out_valid", 65'(b64.out_valid), 65'd1);
        check("lat_imm", {b64.err, b64.imm}, {1'b0, 64'h0000_0000_0000_0FFF});
        @(posedge CLK); #1;
        send64(OP_D,   2'd0, 26'(9'h1F0) << 12,    1'b0, 64'hFFFF_FFFF_FFFF_FFF0);
        send64(OP_CBZ, 2'd0, 26'(19'h40000) << 5,  1'b0, 64'hFFFF_FFFF_FFFC_0000);
        wait_drain();

        // Wide-move chain, back to back.
        send64(OP_MOVZ, 2'd3, 26'(16'h1234) << 5, 1'b0, 64'h1234_0000_0000_0000);
`ifdef IMMGEN_MOVK_EN
        send64(OP_MOVK, 2'd0, 26'(16'hABCD) << 5, 1'b0, 64'h1234_0000_0000_ABCD);
`else
        send64(OP_MOVK, 2'd0, 26'(16'hABCD) << 5, 1'b1, 64'h0);
`endif
        send64(OP_MOVN, 2'd0, 26'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_drain();

        // Backpressure: out_ready low for 4 cycles, offering 1, 2, 3.
        b64.out_ready = 1'b0;
        send64(OP_I, 2'd0, 26'd1 << 10, 1'b0, 64'd1);
        send64(OP_I, 2'd0, 26'd2 << 10, 1'b0, 64'd2);
        b64.op = OP_I; b64.hw = 2'd0; b64.in26 = 26'd3 << 10; b64.in_valid = 1'b1;
        @(negedge CLK);
        check("bp_in_ready_a", 65'(b64.in_ready), 65'd0);
        check("bp_hold_imm_a", {b64.out_valid, b64.imm}, {1'b1, 64'd1});
        @(posedge CLK); #1;
        @(negedge CLK);
        check("bp_in_ready_b", 65'(b64.in_ready), 65'd0);
        check("bp_hold_imm_b", {b64.out_valid, b64.imm}, {1'b1, 64'd1});
        @(posedge CLK); #1;
        b64.out_ready = 1'b1;
        send64(OP_I, 2'd0, 26'd3 << 10, 1'b0, 64'd3);
        wait_drain();

        // WIDTH=32 instance.
        send32(OP_MOVZ, 2'd2, 26'(16'h5555) << 5, 1'b1, 64'h0);
        send32(OP_B,    2'd0, 26'h200_0000,       1'b0, 64'h0000_0000_FE00_0000);
        send32(OP_MOVN, 2'd1, 26'(16'h0001) << 5, 1'b0, 64'h0000_0000_FFFE_FFFF);
        wait_drain();

        // Reserved op leaves the accumulator (all ones after MOVN) alone.
        send64(OP_RSVD, 2'd0, 26'h3FF_FFFF, 1'b1, 64'h0);
`ifdef IMMGEN_MOVK_EN
        send64(OP_MOVK, 2'd0, 26'(16'h0001) << 5, 1'b0, 64'hFFFF_FFFF_FFFF_0001);
`else
        send64(OP_MOVK, 2'd0, 26'(16'h0001) << 5, 1'b1, 64'h0);
`endif
        wait_drain();

        // Reset mid-stream with both buffer entries occupied.
        b64.out_ready = 1'b0;
        send64(OP_MOVZ, 2'd3, 26'(16'h1234) << 5, 1'b0, 64'h1234_0000_0000_0000);
        send64(OP_I, 2'd0, 26'd5 << 10, 1'b0, 64'd5);
        @(negedge CLK);
        check("mid_full_in_ready", 65'(b64.in_ready), 65'd0);
        @(posedge CLK); #1;
        resetn = 1'b0;
        @(posedge CLK); #1;
        resetn = 1'b1;
        q64.delete();
        b64.out_ready = 1'b1;
        @(negedge CLK);
        check("mid_rst_out_valid", 65'(b64.out_valid), 65'd0);
        check("mid_rst_in_ready", 65'(b64.in_ready), 65'd1);
        @(posedge CLK); #1;
`ifdef IMMGEN_MOVK_EN
        send64(OP_MOVK, 2'd0, 26'(16'h0001) << 5, 1'b0, 64'h0000_0000_0000_0001);
`else
        send64(OP_MOVK, 2'd0, 26'(16'h0001) << 5, 1'b1, 64'h0);
`endif
        wait_drain();

        repeat (2) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
